field_accum: RTL and testbench

- Downstream consumer of a field-element stream, such as the result and ready_pulse outputs of the field mux/add/mul cells.
- Sums a programmed number of field elements modulo the field prime `F_Q and presents the total.
- Uses the same edge-triggered en / ready / ready_pulse handshake as the other field arithmetic cells, so it chains directly behind them.
- Used for sum-check term accumulation in the prover pipeline.

---
 rtl/field_accum.sv | 103 ++++++++++
 tb/tb_field_accum.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/field_accum.sv
// Modular accumulator for a stream of field elements, using the en/ready/ready_pulse handshake.
// Optional input range checking is enabled by defining FIELD_ACCUM_RANGE_CHECK_EN.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module field_accum #(
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                en,
  input  logic [CNT_BITS-1:0] count,
  input  logic                in_valid,
  input  logic [`F_NBITS-1:0] in_data,
  output logic                ready_pulse,
  output logic                ready,
  output logic [`F_NBITS-1:0] sum,
  output logic                range_err
);

  localparam logic [`F_NBITS-1:0] Q = `F_Q;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t              state_q, state_d;
  logic                en_dly_q;
  logic                ready_dly_q;
  logic [`F_NBITS-1:0] acc_q, acc_d;
  logic [CNT_BITS-1:0] remaining_q, remaining_d;
  logic                range_err_q, range_err_d;

  logic                start;
  logic [`F_NBITS:0]   add_t;
  logic [`F_NBITS:0]   add_sub;
  logic [`F_NBITS-1:0] add_res;

  assign start       = en & ~en_dly_q;
  assign ready       = (state_q == IDLE) & ~start;
  assign ready_pulse = ready & ~ready_dly_q;
  assign sum         = acc_q;
  assign range_err   = range_err_q;

  // One conditional subtract suffices because both operands are below Q.
  always_comb begin
    add_t   = {1'b0, acc_q} + {1'b0, in_data};
    add_sub = add_t - {1'b0, Q};
    add_res = (add_t >= {1'b0, Q}) ? add_sub[`F_NBITS-1:0] : add_t[`F_NBITS-1:0];
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    range_err_d = range_err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d       = '0;
          remaining_d = count;
          range_err_d = 1'b0;
          if (count != '0) state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d       = add_res;
          remaining_d = remaining_q - CNT_BITS'(1);
`ifdef FIELD_ACCUM_RANGE_CHECK_EN
          if (in_data >= Q) range_err_d = 1'b1;
`endif
          if (remaining_q == CNT_BITS'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // en_dly and ready_dly reset high so neither a start nor a ready_pulse follows reset release.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q     <= IDLE;
      en_dly_q    <= 1'b1;
      ready_dly_q <= 1'b1;
      acc_q       <= '0;
      remaining_q <= '0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_dly_q    <= en;
      ready_dly_q <= ready;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      range_err_q <= range_err_d;
    end
  end

endmodule

// File: tb/tb_field_accum.sv
// Self-checking bench for field_accum: a term-level reference model checked every cycle,
// plus literal expectations for each directed scenario.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module tb_field_accum;

  localparam int CNT_BITS = 8;
  localparam longint unsigned Q = 64'(`F_Q);
`ifdef FIELD_ACCUM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rstb;
  logic                en;
  logic [CNT_BITS-1:0] count;
  logic                in_valid;
  logic [`F_NBITS-1:0] in_data;
  logic                ready_pulse;
  logic                ready;
  logic [`F_NBITS-1:0] sum;
  logic                range_err;

  int total = 0;
  int bad   = 0;
  int pulses_seen = 0;

  field_accum #(.CNT_BITS(CNT_BITS)) dut (
    .clk(clk), .rstb(rstb), .en(en), .count(count),
    .in_valid(in_valid), .in_data(in_data),
    .ready_pulse(ready_pulse), .ready(ready), .sum(sum), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks whether a job is open, terms still owed and the sum mod Q.
  bit              m_busy;
  int              m_left;
  longint unsigned m_sum;
  bit              m_en_prev, m_ready_prev, m_rerr;

  always @(negedge clk) begin
    bit m_start, e_ready, e_pulse;
    if (!rstb) begin
      m_busy = 0; m_left = 0; m_sum = 0; m_rerr = 0;
      m_en_prev = 1; m_ready_prev = 1;
    end
    m_start = en && !m_en_prev;
    e_ready = !m_busy && !m_start;
    e_pulse = e_ready && !m_ready_prev;
    check("ready", 64'(ready), 64'(e_ready));
    check("ready_pulse", 64'(ready_pulse), 64'(e_pulse));
    check("range_err", 64'(range_err), 64'(m_rerr));
    if (e_ready) check("sum", 64'(sum), m_sum);
    if (ready_pulse) pulses_seen++;
    // Inputs are stable until after the next rising edge, so advance the model now.
    if (rstb) begin
      if (!m_busy && m_start) begin
        m_sum = 0; m_left = int'(count); m_busy = (count != 0); m_rerr = 0;
      end else if (m_busy && in_valid) begin
        m_sum = (m_sum + 64'(in_data)) % Q;
        if (RC && 64'(in_data) >= Q) m_rerr = 1;
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
      m_en_prev = en;
      m_ready_prev = e_ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d[`F_NBITS-1:0];
    step();
    in_valid = 1'b0;
  endtask

  task automatic start_job(input int n);
    count = CNT_BITS'(n);
    en = 1'b1;
    step();
    en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    logic [63:0] qm1;
    qm1 = Q - 1;
    rstb = 1'b0; en = 1'b0; count = '0; in_valid = 1'b0; in_data = '0;
    step(); step();
    rstb = 1'b1;
    repeat (4) step();
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_no_pulse", 64'(pulses_seen), 64'd0);

    // Three back-to-back terms.
    p0 = pulses_seen;
    start_job(3);
    strobe(5); in_valid = 1'b1; in_data = 7; step(); in_data = 11; step(); in_valid = 1'b0;
    check("sum3_pulse_now", 64'(ready_pulse), 64'd1);
    step(); step();
    check("sum3_value", 64'(sum), 64'd23);
    check("sum3_one_pulse", 64'(pulses_seen - p0), 64'd1);

    // Zero-term job.
    p0 = pulses_seen;
    start_job(0);
    check("cnt0_pulse_now", 64'(ready_pulse), 64'd1);
    step(); step();
    check("cnt0_sum", 64'(sum), 64'd0);
    check("cnt0_one_pulse", 64'(pulses_seen - p0), 64'd1);

    // Wrap-around reduction.
    start_job(2); strobe(qm1); strobe(2); step(); step();
    check("wrap_sum1", 64'(sum), 64'd1);
    start_job(2); strobe(qm1); strobe(1); step(); step();
    check("wrap_sum0", 64'(sum), 64'd0);

    // Idle strobes ignored, gaps in the stream, second en edge ignored, en held high.
    strobe(9999); step(); strobe(4444); step();
    check("idle_ignored", 64'(sum), 64'd0);
    count = 4; en = 1'b1; step();          // cycle 0: start
    strobe(100);                           // cycle 1 (en still high)
    en = 1'b0; step();                     // cycle 2
    en = 1'b1; count = 7; step();          // cycle 3: ignored edge, en now held high
    strobe(200); strobe(300);              // cycles 4,5
    repeat (3) step();                     // cycles 6..8
    strobe(400);                           // cycle 9
    repeat (4) step();
    check("gap_sum", 64'(sum), 64'd1000);
    check("gap_no_restart", 64'(ready), 64'd1);
    en = 1'b0; step();

    // Reset mid-accumulation.
    start_job(4); strobe(50); strobe(60);
    rstb = 1'b0;
    #1;
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_ready", 64'(ready), 64'd1);
    step(); step();
    rstb = 1'b1;
    repeat (2) step();

    // Large count: no counter wrap, job completes after 255 terms.
    start_job(255);
    for (int i = 0; i < 255; i++) strobe(64'(i + 1));
    step(); step();
    check("cnt255_sum", 64'(sum), 64'd32640);

`ifdef FIELD_ACCUM_RANGE_CHECK_EN
    start_job(2); strobe(Q); strobe(3); step();
    check("range_set", 64'(range_err), 64'd1);
    start_job(1);
    check("range_cleared", 64'(range_err), 64'd0);
    strobe(4); step();
`else
    start_job(2); strobe(10); strobe(3); step();
    check("range_tied0", 64'(range_err), 64'd0);
`endif
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
